// File: rtl/add_chain_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : add_chain_ctrl
// Purpose  : Byte-serial sequencer around a shared 8-bit carry-lookahead
//            adder. Streams LSB-first operand byte pairs through the adder,
//            chains carry between bytes and returns result bytes over a
//            valid/ready stream, forming an NBYTES x 8-bit add/subtract unit.
// Revision : 1.0 - initial release
// ============================================================================
module add_chain_ctrl #(
   parameter int NBYTES = 4
) (
   input  logic       clk,
   input  logic       rst,
   // operation control
   input  logic       start,
   input  logic       sub,
   // operand stream
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] a_byte,
   input  logic [7:0] b_byte,
   // result stream
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] sum_byte,
   output logic       out_last,
   // shared adder datapath
   output logic [7:0] add_a,
   output logic [7:0] add_b,
   output logic       add_cin,
   input  logic [7:0] add_sum,
   input  logic       add_cout,
   // status
   output logic       busy,
   output logic       done,
   output logic       cout,
   output logic       zero
);

   // Counter is wide enough to hold NBYTES so the final increment never wraps.
   localparam int CNT_W = $clog2(NBYTES + 1);
   localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(NBYTES - 1);
   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic             r_sub;        // operation latched at start
   logic             r_carry;      // carry chained between bytes
   logic [CNT_W-1:0] r_cnt;        // bytes accepted so far
   logic             r_zacc;       // all result bytes so far were zero
   logic             r_out_valid;
   logic [7:0]       r_sum;
   logic             r_last;
   logic             r_done;
   logic             r_cout;
   logic             r_zero;

   logic             w_accept;     // operand byte pair taken this cycle
   logic             w_out_hs;     // result byte handed downstream this cycle
   logic             w_start_go;   // start honoured in IDLE
   logic             w_finish;     // final result byte handed off

   assign w_out_hs   = r_out_valid && out_ready;
   assign w_start_go = (r_state == ST_IDLE) && start;
   assign w_finish   = (r_state == ST_FLUSH) && w_out_hs;

   assign out_valid  = r_out_valid;
   assign sum_byte   = r_sum;
   assign out_last   = r_last;
   assign done       = r_done;
   assign cout       = r_cout;
   assign zero       = r_zero;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode plus operand-side handshake and adder drive.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      busy        = 1'b1;
      w_accept    = 1'b0;
      add_a       = 8'h00;
      add_b       = 8'h00;
      add_cin     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            // Single-entry output register: take a new byte only if the
            // held one is empty or leaving this cycle.
            in_ready = !r_out_valid || out_ready;
            w_accept = in_valid && in_ready;
            add_a    = a_byte;
            add_b    = r_sub ? ~b_byte : b_byte;
            add_cin  = r_carry;
            if (w_accept && (r_cnt == c_last_idx)) begin
               w_state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (w_out_hs) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            busy        = 1'b0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Per-operation context: op select, carry chain, byte count, zero tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sub   <= 1'b0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_zacc  <= 1'b0;
      end else if (w_start_go) begin
         // Subtract is A + ~B + 1: the +1 enters as the first carry-in.
         r_sub   <= sub;
         r_carry <= sub;
         r_cnt   <= '0;
         r_zacc  <= 1'b1;
      end else if (w_accept) begin
         r_carry <= add_cout;
         r_cnt   <= r_cnt + c_cnt_one;
         r_zacc  <= r_zacc & (add_sum == 8'h00);
      end
   end

   // Result output register; contents hold while the downstream stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_sum       <= 8'h00;
         r_last      <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_sum       <= add_sum;
         r_last      <= (r_cnt == c_last_idx);
      end else if (w_out_hs) begin
         r_out_valid <= 1'b0;
      end
   end

   // Completion pulse and sticky status of the last finished operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_done <= 1'b0;
         r_cout <= 1'b0;
         r_zero <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_finish) begin
            r_cout <= r_carry;
            r_zero <= r_zacc;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/add_chain_ctrl.md
# add_chain_ctrl

Sequencer that runs multi-byte add/subtract operations through the shared 8-bit carry-lookahead adder. It streams operand byte pairs least-significant byte first and drives the adder's A, B and carry-in. It chains each byte's carry-out into the next byte and returns result bytes over a valid/ready stream. It sits between the pin-level operand interface and the combinational CLA datapath, turning the 8-bit adder into an NBYTES×8-bit adder/subtractor.

## Interface
- NBYTES, 4: operand length in bytes; legal range 1..16.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin an operation; sampled only in IDLE.
- sub  in  1  operation select, latched with start: 0 = A+B, 1 = A−B.
- in_valid  in  1  operand byte pair present.
- in_ready  out  1  controller accepts operand byte pair this cycle.
- a_byte  in  8  operand A byte, LSB-first order.
- b_byte  in  8  operand B byte, LSB-first order.
- out_valid  out  1  result byte present.
- out_ready  in  1  downstream accepts result byte.
- sum_byte  out  8  result byte.
- out_last  out  1  qualifies the final result byte of an operation.
- add_a  out  8  to adder operand A.
- add_b  out  8  to adder operand B.
- add_cin  out  1  to adder carry-in.
- add_sum  in  8  from adder sum.
- add_cout  in  1  from adder carry-out.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- cout  out  1  final carry of the last operation. For subtract, 1 means no borrow.
- zero  out  1  all result bytes of the last operation were 0x00.

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE:
  - busy=0, in_ready=0.
  - start=1 latches sub, sets carry register to sub, clears byte counter, sets zero-accumulator to 1, then goes to RUN.
- RUN:
  - in_ready = !out_valid || out_ready (single-entry output register).
  - Adder drive (combinational): add_a = a_byte; add_b = sub ? ~b_byte : b_byte; add_cin = carry register.
  - On accept (in_valid && in_ready):
    - output register ← add_sum; carry ← add_cout.
    - zero-accumulator &= (add_sum == 0).
    - counter++.
    - out_last ← (counter == NBYTES−1).
  - Accepting byte NBYTES−1 moves to FLUSH.
- Outside RUN: add_a, add_b and add_cin are 0.
- FLUSH:
  - in_ready=0.
  - On the out_valid && out_ready handshake of the last byte, go to IDLE.
  - On that same edge, latch cout ← carry and zero ← zero-accumulator, and assert done for the next cycle.
- Output stream:
  - out_valid, sum_byte and out_last hold stable while out_valid && !out_ready.
  - out_valid clears on handshake unless a new byte is accepted in the same cycle.
- start outside IDLE is ignored. sub is ignored except at start.
- Carry arithmetic:
  - Width is exactly 8 bits per byte; there is no saturation.
  - Subtract is A + ~B + 1, the two's complement of B applied across all NBYTES.
- NBYTES=1: RUN accepts one byte, then goes to FLUSH. Behaviour is otherwise identical.
- Reset (any state, including mid-operation):
  - Next cycle: state IDLE.
  - in_ready=0, out_valid=0, sum_byte=0, out_last=0.
  - busy=0, done=0, cout=0, zero=0.
  - Carry, counter and accumulator cleared.
  - Partial results are discarded.

## Timing
- start in IDLE at cycle t: busy=1 and in_ready can be 1 at t+1.
- Byte accepted at cycle t: out_valid=1 with its sum at t+1.
  - Throughput is 1 byte/cycle while out_ready=1.
- Last byte handshake at cycle t:
  - busy=0 and done=1 at t+1 only.
  - cout and zero are updated at t+1 and held until the next operation's completion or reset.
- A start at t+1 (while done=1) is accepted, since the state is IDLE.
- Backpressure: out_ready=0 with out_valid=1 forces in_ready=0 in the same cycle. No byte is lost or duplicated.

## Test plan
- Add, NBYTES=4, A=0x12345678, B=0x000000FF:
  - sum_byte sequence 0x77, 0x57, 0x34, 0x12.
  - out_last only on 0x12.
  - cout=0, zero=0, done pulses once.
- Add overflow, A=0xFFFFFFFF, B=0x00000001:
  - bytes 0x00 ×4.
  - cout=1, zero=1.
- Subtract equal, A=0x00000001, B=0x00000001:
  - bytes 0x00 ×4.
  - cout=1, zero=1.
  - add_cin=1 on the first byte.
- Subtract borrow, A=0, B=1:
  - bytes 0xFF ×4.
  - cout=0, zero=0.
- Backpressure: hold out_ready=0 for 3 cycles after byte 1 with in_valid constantly 1.
  - in_ready=0 throughout.
  - sum_byte stable.
  - The full stream is correct afterwards with no drop or duplicate.
- Robustness:
  - start pulsed during RUN is ignored.
  - rst asserted after byte 2: the next cycle shows all outputs at their reset values.
  - A fresh add of 0x01010101+0x01010101 then gives 0x02 ×4.
